// File: rtl/wb_inst_feeder.sv
// wb_inst_feeder: Wishbone slave on the Amber 128-bit port.
//   Instruction side: 32-bit words pushed by the driver (inst_valid/inst_data/inst_ready)
//     are buffered and returned to core reads as one lane of a 128-bit line, NOP-filled.
//   Core bus: o_wb_* in from the core, i_wb_dat/i_wb_ack/i_wb_err back; registered
//     one-cycle ack, at most one transfer every two cycles.
//   Write side: core write cycles are captured into a FIFO presented on
//     wr_valid/wr_ready/wr_adr/wr_dat/wr_sel for the result monitor.
//   Status: fetch_adr (last acked read address), inst_count, nop_count (wrapping).
module wb_inst_feeder #(
   parameter int unsigned IDEPTH         = 8,
   parameter int unsigned WDEPTH         = 4,
   parameter logic [31:0] NOP_WORD       = 32'hF0801003,
   parameter bit          STALL_ON_EMPTY = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   // instruction driver
   input  logic         inst_valid,
   input  logic [31:0]  inst_data,
   output logic         inst_ready,
   // core wishbone master
   input  logic [31:0]  o_wb_adr,
   input  logic [15:0]  o_wb_sel,
   input  logic         o_wb_we,
   input  logic [127:0] o_wb_dat,
   input  logic         o_wb_cyc,
   input  logic         o_wb_stb,
   output logic [127:0] i_wb_dat,
   output logic         i_wb_ack,
   output logic         i_wb_err,
   // write-capture monitor port
   output logic         wr_valid,
   input  logic         wr_ready,
   output logic [31:0]  wr_adr,
   output logic [127:0] wr_dat,
   output logic [15:0]  wr_sel,
   // status
   output logic [31:0]  fetch_adr,
   output logic [15:0]  inst_count,
   output logic [15:0]  nop_count
);

   localparam int unsigned IAW    = $clog2(IDEPTH);
   localparam int unsigned IPW    = IAW + 1;
   localparam int unsigned WAW    = $clog2(WDEPTH);
   localparam int unsigned WPW    = WAW + 1;
   localparam int unsigned WENT_W = 32 + 128 + 16;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_e;

   // ------------------------------------------------------------------
   // Instruction FIFO (pointers carry one extra wrap bit)
   // ------------------------------------------------------------------
   logic [31:0]    imem_q [IDEPTH];
   logic [IPW-1:0] iwr_q, ird_q;
   logic           ifull, iempty, ipush, ipop;
   logic [31:0]    ihead;

   assign ifull      = (iwr_q[IAW] != ird_q[IAW]) && (iwr_q[IAW-1:0] == ird_q[IAW-1:0]);
   assign iempty     = (iwr_q == ird_q);
   assign ipush      = inst_valid & ~ifull;
   assign ihead      = imem_q[ird_q[IAW-1:0]];
   assign inst_ready = ~ifull;

   // Instruction FIFO pointers
   always_ff @(posedge clk) begin
      if (reset) begin
         iwr_q <= '0;
         ird_q <= '0;
      end else begin
         if (ipush) iwr_q <= iwr_q + IPW'(1);
         if (ipop)  ird_q <= ird_q + IPW'(1);
      end
   end

   // Instruction FIFO storage
   always_ff @(posedge clk) begin
      if (ipush) imem_q[iwr_q[IAW-1:0]] <= inst_data;
   end

   // ------------------------------------------------------------------
   // Write-capture FIFO, entry layout {adr, dat, sel}
   // ------------------------------------------------------------------
   logic [WENT_W-1:0] wmem_q [WDEPTH];
   logic [WPW-1:0]    wwr_q, wrd_q;
   logic              wfull, wempty, wpush, wpop;
   logic [WENT_W-1:0] whead;

   assign wfull    = (wwr_q[WAW] != wrd_q[WAW]) && (wwr_q[WAW-1:0] == wrd_q[WAW-1:0]);
   assign wempty   = (wwr_q == wrd_q);
   assign wpop     = ~wempty & wr_ready;
   assign whead    = wmem_q[wrd_q[WAW-1:0]];
   assign wr_valid = ~wempty;
   assign wr_adr   = whead[WENT_W-1 -: 32];
   assign wr_dat   = whead[143:16];
   assign wr_sel   = whead[15:0];

   // Capture FIFO pointers
   always_ff @(posedge clk) begin
      if (reset) begin
         wwr_q <= '0;
         wrd_q <= '0;
      end else begin
         if (wpush) wwr_q <= wwr_q + WPW'(1);
         if (wpop)  wrd_q <= wrd_q + WPW'(1);
      end
   end

   // Capture FIFO storage
   always_ff @(posedge clk) begin
      if (wpush) wmem_q[wwr_q[WAW-1:0]] <= {o_wb_adr, o_wb_dat, o_wb_sel};
   end

   // ------------------------------------------------------------------
   // Bus FSM
   // ------------------------------------------------------------------
   state_e         state_q, state_d;
   logic           ack_q, ack_d;
   logic           err_q, err_d;
   logic [127:0]   dat_q, dat_d;
   logic [31:0]    fetch_q, fetch_d;
   logic [15:0]    icnt_q, icnt_d;
   logic [15:0]    ncnt_q, ncnt_d;
   logic [127:0]   read_line;
   logic           req;

   assign req = o_wb_cyc & o_wb_stb;

   // Fetched word goes into the lane selected by adr[3:2]; other lanes carry NOPs
   always_comb begin
      read_line = '0;
      for (int l = 0; l < 4; l++) begin
         read_line[32*l +: 32] = (o_wb_adr[3:2] == 2'(l)) ? ihead : NOP_WORD;
      end
   end

   // Next-state and transfer decisions
   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_d   = dat_q;
      fetch_d = fetch_q;
      icnt_d  = icnt_q;
      ncnt_d  = ncnt_q;
      ipop    = 1'b0;
      wpush   = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               if (o_wb_sel == 16'h0) begin
                  err_d   = 1'b1;
                  state_d = ACK;
               end else if (o_wb_we) begin
                  // full FIFO still accepts when the head leaves this same cycle
                  if (!wfull || wpop) begin
                     wpush   = 1'b1;
                     ack_d   = 1'b1;
                     state_d = ACK;
                  end
               end else if (!iempty) begin
                  ipop    = 1'b1;
                  dat_d   = read_line;
                  fetch_d = o_wb_adr;
                  icnt_d  = icnt_q + 16'd1;
                  ack_d   = 1'b1;
                  state_d = ACK;
               end else if (!STALL_ON_EMPTY) begin
                  dat_d   = {4{NOP_WORD}};
                  fetch_d = o_wb_adr;
                  ncnt_d  = ncnt_q + 16'd1;
                  ack_d   = 1'b1;
                  state_d = ACK;
               end
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         fetch_q <= '0;
         icnt_q  <= '0;
         ncnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
         fetch_q <= fetch_d;
         icnt_q  <= icnt_d;
         ncnt_q  <= ncnt_d;
      end
   end

   assign i_wb_dat   = dat_q;
   assign i_wb_ack   = ack_q;
   assign i_wb_err   = err_q;
   assign fetch_adr  = fetch_q;
   assign inst_count = icnt_q;
   assign nop_count  = ncnt_q;

endmodule
